// File: rtl/alu_subpipeline_p.sv
// alu_subpipeline_p: ID/EX reg, EX stage, EX/WB reg, branch decision; define ALU_PIPE_FWD_EN for EX/WB->EX forwarding
module alu_subpipeline_p #(
    parameter int DATA_W = 32,
    parameter int PC_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              hold,
    input  logic [PC_W-1:0]   IDpc,
    input  logic [31:0]       IDinstruction,
    input  logic [DATA_W-1:0] regbusA,
    input  logic [DATA_W-1:0] regbusB,
    input  logic              ExtOp,
    input  logic              ALUSrc,
    input  logic [2:0]        ALUOp,
    input  logic              RegDst,
    input  logic [1:0]        Branch,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] BusW,
    output logic [REG_AW-1:0] regmuxout,
    output logic              wb_we,
    output logic              branch_ctrl,
    output logic [PC_W-1:0]   MEMpc
);
    logic              s1_valid;
    logic [PC_W-1:0]   s1_pc;
    logic [25:0]       s1_ins;
    logic [DATA_W-1:0] s1_a, s1_b;
    logic              s1_extop, s1_alusrc, s1_regdst, s1_regwrite;
    logic [2:0]        s1_aluop;
    logic [1:0]        s1_branch;
    logic              s2_valid, s2_fresh, s2_regwrite, s2_taken;
    logic [DATA_W-1:0] op_a, op_b, ext, alu_b, alu_y;
    logic [PC_W-1:0]   target;
    logic [REG_AW-1:0] dst;
    logic [15:0]       imm;
    logic              zero, taken, advance, transfer, unused;

    assign in_ready = !rst && !hold && !branch_ctrl;
    assign transfer = in_valid && in_ready;
    assign wb_we = s2_valid && s2_fresh && s2_regwrite;
    assign branch_ctrl = s2_valid && s2_fresh && s2_taken;
    assign advance = s1_valid && !branch_ctrl;
    assign imm = s1_ins[15:0];

`ifdef ALU_PIPE_FWD_EN
    logic fwd_ok;
    assign fwd_ok = s2_valid && s2_regwrite && regmuxout != '0;
    assign op_a = (fwd_ok && regmuxout == REG_AW'(s1_ins[25:21])) ? BusW : s1_a;
    assign op_b = (fwd_ok && regmuxout == REG_AW'(s1_ins[20:16])) ? BusW : s1_b;
    assign unused = ^IDinstruction[31:26];
`else
    assign op_a = s1_a;
    assign op_b = s1_b;
    assign unused = ^{IDinstruction[31:26], s1_ins[25:21]};
`endif

    assign ext = s1_extop ? DATA_W'($signed(imm)) : DATA_W'(imm);
    assign alu_b = s1_alusrc ? ext : op_b;
    assign zero = (op_a - alu_b) == '0;
    assign target = s1_pc + PC_W'(4) + (PC_W'($signed(imm)) << 2);
    assign dst = s1_regdst ? REG_AW'(s1_ins[15:11]) : REG_AW'(s1_ins[20:16]);
    assign taken = s1_branch == 2'b01 ? zero :
                   s1_branch == 2'b10 ? !zero :
                   s1_branch == 2'b11 ? (!op_a[DATA_W-1] && op_a != '0) : 1'b0;

    always_comb begin
        alu_y = '0;
        case (s1_aluop)
            3'b000: alu_y = op_a + alu_b;
            3'b001: alu_y = op_a - alu_b;
            3'b010: alu_y = op_a & alu_b;
            3'b011: alu_y = op_a | alu_b;
            3'b100: alu_y = op_a ^ alu_b;
            3'b101: alu_y = DATA_W'($signed(op_a) < $signed(alu_b));
            3'b110: alu_y = DATA_W'(op_a < alu_b);
            default: alu_y = ~(op_a | alu_b);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            s1_valid <= 1'b0;
        else if (!hold)
            s1_valid <= transfer;
        else if (branch_ctrl)
            s1_valid <= 1'b0;
        if (transfer) begin
            s1_pc       <= IDpc;
            s1_ins      <= IDinstruction[25:0];
            s1_a        <= regbusA;
            s1_b        <= regbusB;
            s1_extop    <= ExtOp;
            s1_alusrc   <= ALUSrc;
            s1_aluop    <= ALUOp;
            s1_regdst   <= RegDst;
            s1_branch   <= Branch;
            s1_regwrite <= RegWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            s2_fresh    <= 1'b0;
            s2_regwrite <= 1'b0;
            s2_taken    <= 1'b0;
            BusW        <= '0;
            regmuxout   <= '0;
            MEMpc       <= '0;
        end else if (hold) begin
            s2_fresh <= 1'b0;
        end else begin
            s2_valid <= advance;
            s2_fresh <= advance;
            if (advance) begin
                s2_regwrite <= s1_regwrite;
                s2_taken    <= taken;
                BusW        <= alu_y;
                regmuxout   <= dst;
                MEMpc       <= target;
            end
        end
    end
endmodule
